// File: rtl/idli_serial_alu.sv
// Slice-serial ALU: operands arrive LSB slice first, one registered result slice per cycle.
// Optional shift-left-by-1 of A is enabled by defining IDLI_SERIAL_ALU_SHL_EN.
module idli_serial_alu #(
   parameter int DATA_W  = 16,
   parameter int SLICE_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   output logic               o_ready,
   input  logic [1:0]         i_op,
   input  logic               i_sub,
   input  logic               i_shl,
   input  logic [SLICE_W-1:0] i_lhs,
   input  logic [SLICE_W-1:0] i_rhs,
   output logic [SLICE_W-1:0] o_res,
   output logic               o_res_vld,
   output logic               o_done,
   output logic               o_carry,
   output logic               o_zero
);

   localparam int NSLICE = DATA_W / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      ALU_OP_ADD = 2'd0,
      ALU_OP_AND = 2'd1,
      ALU_OP_OR  = 2'd2,
      ALU_OP_XOR = 2'd3
   } alu_op_t;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   typedef struct packed {
      alu_op_t op;
      logic    sub;
   } ctrl_t;

   state_t             state_q, state_d;
   ctrl_t              ctrl_q, ctrl_d, ctrl;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               zacc_q, zacc_d;
   logic [SLICE_W-1:0] res_q, res_d;
   logic               res_vld_q, res_vld_d;
   logic               done_q, done_d;
   logic               cflag_q, cflag_d;
   logic               zflag_q, zflag_d;

   logic               accept, consume, last, shl, cin, cout;
   logic [SLICE_W-1:0] res;
   logic [SLICE_W:0]   sum;

`ifdef IDLI_SERIAL_ALU_SHL_EN
   logic             shl_q, shl_d;
   logic [SLICE_W:0] shifted;
`else
   logic             unused_shl;
   assign unused_shl = i_shl;
`endif

   always_comb begin
      accept  = (state_q == ST_IDLE) && i_start;
      consume = accept || (state_q == ST_RUN);
      ctrl    = ctrl_q;
      if (accept) begin
         ctrl.op  = alu_op_t'(i_op);
         ctrl.sub = i_sub;
      end
`ifdef IDLI_SERIAL_ALU_SHL_EN
      shl_d = accept ? i_shl : shl_q;
      shl   = shl_d;
`else
      shl   = 1'b0;
`endif
      // Slice 0 takes its carry-in from the op (1 for subtract); later slices from the carry flop.
      cin  = accept ? (i_sub && (ctrl.op == ALU_OP_ADD) && !shl) : carry_q;
      sum  = {1'b0, i_lhs} + {1'b0, (ctrl.sub ? ~i_rhs : i_rhs)} + {{SLICE_W{1'b0}}, cin};
      res  = '0;
      cout = 1'b0;
`ifdef IDLI_SERIAL_ALU_SHL_EN
      shifted = {i_lhs, cin};
      if (shl) begin
         res  = shifted[SLICE_W-1:0];
         cout = shifted[SLICE_W];
      end else
`endif
      begin
         case (ctrl.op)
            ALU_OP_ADD: begin
               res  = sum[SLICE_W-1:0];
               cout = sum[SLICE_W];
            end
            ALU_OP_AND: res = i_lhs & i_rhs;
            ALU_OP_OR:  res = i_lhs | i_rhs;
            default:    res = i_lhs ^ i_rhs;
         endcase
      end
      last = accept ? (NSLICE == 1) : (cnt_q == LAST);

      state_d   = state_q;
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      zacc_d    = zacc_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      done_d    = 1'b0;
      cflag_d   = cflag_q;
      zflag_d   = zflag_q;
      if (consume) begin
         ctrl_d    = ctrl;
         res_d     = res;
         res_vld_d = 1'b1;
         carry_d   = cout;
         zacc_d    = (accept ? 1'b0 : zacc_q) | (|res);
         if (last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            cflag_d = cout;
            zflag_d = ~zacc_d;
         end else begin
            state_d = ST_RUN;
            cnt_d   = accept ? CNT_W'(1) : cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         zacc_q    <= 1'b0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         done_q    <= 1'b0;
         cflag_q   <= 1'b0;
         zflag_q   <= 1'b0;
`ifdef IDLI_SERIAL_ALU_SHL_EN
         shl_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         zacc_q    <= zacc_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         done_q    <= done_d;
         cflag_q   <= cflag_d;
         zflag_q   <= zflag_d;
`ifdef IDLI_SERIAL_ALU_SHL_EN
         shl_q     <= shl_d;
`endif
      end
   end

   assign o_ready   = (state_q == ST_IDLE);
   assign o_res     = res_q;
   assign o_res_vld = res_vld_q;
   assign o_done    = done_q;
   assign o_carry   = cflag_q;
   assign o_zero    = zflag_q;

endmodule

// File: tb/tb_idli_serial_alu.sv
// Directed bench for idli_serial_alu (DATA_W=16, SLICE_W=4): per-slice results, flags, handshakes.
module tb_idli_serial_alu;

   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic [1:0] i_op = 2'd0;
   logic       i_sub = 1'b0;
   logic       i_shl = 1'b0;
   logic [3:0] i_lhs = 4'd0;
   logic [3:0] i_rhs = 4'd0;
   logic       o_ready, o_res_vld, o_done, o_carry, o_zero;
   logic [3:0] o_res;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   idli_serial_alu #(.DATA_W(16), .SLICE_W(4)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .o_ready(o_ready),
      .i_op(i_op), .i_sub(i_sub), .i_shl(i_shl), .i_lhs(i_lhs), .i_rhs(i_rhs),
      .o_res(o_res), .o_res_vld(o_res_vld), .o_done(o_done),
      .o_carry(o_carry), .o_zero(o_zero)
   );

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams one op; optionally pokes an ignored start mid-op and chains the next op's start.
   task automatic run_op(input string tag, input logic [1:0] op, input logic sub, input logic shl,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_r,
                         input logic ec, input logic ez, input bit pre, input bit poke,
                         input bit chain, input logic [1:0] nop, input logic nsub,
                         input logic [15:0] na, input logic [15:0] nb);
      if (!pre) begin
         i_start = 1'b1; i_op = op; i_sub = sub; i_shl = shl;
         i_lhs = a[3:0]; i_rhs = b[3:0];
      end
      for (int j = 0; j < NS; j++) begin
         tick();
         i_start = 1'b0;
         check({tag, "_res"}, 16'(o_res), 16'(exp_r[j*4 +: 4]));
         check({tag, "_vld"}, 16'(o_res_vld), 16'd1);
         check({tag, "_done"}, 16'(o_done), 16'(j == NS - 1));
         check({tag, "_rdy"}, 16'(o_ready), 16'(j == NS - 1));
         if (j < NS - 1) begin
            i_lhs = a[(j+1)*4 +: 4];
            i_rhs = b[(j+1)*4 +: 4];
         end
         if (poke && j == 1) begin
            i_start = 1'b1; i_op = 2'd3; i_sub = 1'b1;
         end
         if (chain && j == NS - 1) begin
            i_start = 1'b1; i_op = nop; i_sub = nsub; i_shl = 1'b0;
            i_lhs = na[3:0]; i_rhs = nb[3:0];
         end
      end
      check({tag, "_carry"}, 16'(o_carry), 16'(ec));
      check({tag, "_zero"}, 16'(o_zero), 16'(ez));
   endtask

   task automatic op1(input string tag, input logic [1:0] op, input logic sub, input logic shl,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_r,
                      input logic ec, input logic ez);
      run_op(tag, op, sub, shl, a, b, exp_r, ec, ez, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0);
   endtask

   initial begin
      tick();
      tick();
      check("rst_rdy", 16'(o_ready), 16'd1);
      check("rst_vld", 16'(o_res_vld), 16'd0);
      check("rst_done", 16'(o_done), 16'd0);
      check("rst_res", 16'(o_res), 16'd0);
      check("rst_flags", {14'd0, o_carry, o_zero}, 16'd0);
      i_rst = 1'b0;
      tick();

      op1("add", 2'd0, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
      tick();
      check("idle_vld", 16'(o_res_vld), 16'd0);
      check("idle_done", 16'(o_done), 16'd0);
      op1("addwrap", 2'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
      tick();
      check("hold_flags", {14'd0, o_carry, o_zero}, 16'd3);
      op1("subneg", 2'd0, 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
      op1("subeq", 2'd0, 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1);
      op1("xor", 2'd3, 1'b1, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0);
      op1("and", 2'd1, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
      op1("andz", 2'd1, 1'b0, 1'b0, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b1);
      op1("or", 2'd2, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);

      // Ignored start at k+2, back-to-back accept at k+4.
      run_op("b2b_a", 2'd0, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'hA5A5, 16'hFFFF);
      run_op("b2b_b", 2'd3, 1'b0, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0,
             1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0);
      tick();

`ifdef IDLI_SERIAL_ALU_SHL_EN
      op1("shl", 2'd0, 1'b0, 1'b1, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0);
`else
      op1("shl_off", 2'd0, 1'b0, 1'b1, 16'h8001, 16'h0001, 16'h8002, 1'b0, 1'b0);
`endif
      tick();

      // Reset mid-op after flags were left set.
      op1("pre_rst", 2'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
      i_start = 1'b1; i_op = 2'd0; i_sub = 1'b1; i_shl = 1'b0;
      i_lhs = 4'h5; i_rhs = 4'h7;
      tick();
      i_start = 1'b0; i_lhs = 4'h0; i_rhs = 4'h0;
      tick();
      i_rst = 1'b1;
      tick();
      check("mrst_rdy", 16'(o_ready), 16'd1);
      check("mrst_vld", 16'(o_res_vld), 16'd0);
      check("mrst_done", 16'(o_done), 16'd0);
      check("mrst_flags", {14'd0, o_carry, o_zero}, 16'd0);
      i_rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("mrst_nodone", {14'd0, o_done, o_res_vld}, 16'd0);
      end
      op1("post_rst", 2'd0, 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
